// File: rtl/alu_pkt_pkg.sv
// alu_pkt_pkg -- shared opcodes, FSM states and ALU op codes for alu_pkt_ctrl.
// Rev 1.0
`default_nettype none

package alu_pkt_pkg;

  localparam logic [7:0]  OPC_ECHO = 8'hEC;
  localparam logic [7:0]  OPC_ADD  = 8'hAD;
  localparam logic [7:0]  OPC_MUL  = 8'h88;
  localparam logic [7:0]  OPC_DIV  = 8'hD1;
  localparam logic [15:0] HDR_LEN  = 16'd4;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_ECHO  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_REQ   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_SEND  = 3'd5,
    ST_DRAIN = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_MUL = 2'd1,
    ALU_DIV = 2'd2
  } alu_op_e;

  function automatic alu_op_e opc_to_aluop(input logic [7:0] opc);
    case (opc)
      OPC_MUL: return ALU_MUL;
      OPC_DIV: return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_pkt_ctrl.sv
// alu_pkt_ctrl -- parses UART byte packets, echoes, drains or drives an ALU and returns its result.
// Rev 1.0
`default_nettype none

module alu_pkt_ctrl
  import alu_pkt_pkg::*;
#(
  parameter int opw_p       = 32,
  parameter int datawidth_p = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [1:0]             alu_op_o,
  output logic [opw_p-1:0]       alu_a_o,
  output logic [opw_p-1:0]       alu_b_o,
  output logic                   alu_valid_o,
  input  logic                   alu_ready_i,
  input  logic [opw_p-1:0]       alu_result_i,
  input  logic                   alu_result_valid_i
);

  localparam int BW  = datawidth_p;
  localparam int NB  = opw_p / BW;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(NB - 1);

  state_e           state_q, state_d;
  logic [1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [7:0]       opc_q, opc_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      pay_cnt_q, pay_cnt_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [opw_p-1:0] acc_q, acc_d;
  logic [opw_p-1:0] opnd_q, opnd_d;
  logic             have_acc_q, have_acc_d;
  logic             run_q;

  logic [15:0]      pay_len;
  logic             pay_last;
  logic             pay_done;
  logic [opw_p-1:0] opnd_shift;

  assign pay_len  = len_q - HDR_LEN;
  assign pay_last = (pay_cnt_q + 16'd1) == pay_len;
  assign pay_done = pay_cnt_q == pay_len;

  // Operand bytes arrive LSB first: shift in at the top so byte 0 ends at [BW-1:0].
  if (NB > 1) begin : g_shift_multi
    assign opnd_shift = {rx_data_i, opnd_q[opw_p-1:BW]};
  end else begin : g_shift_single
    assign opnd_shift = rx_data_i;
  end

  assign alu_op_o = opc_to_aluop(opc_q);
  assign alu_a_o  = acc_q;
  assign alu_b_o  = opnd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_HDR;
      hdr_cnt_q  <= '0;
      opc_q      <= '0;
      len_q      <= '0;
      pay_cnt_q  <= '0;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      have_acc_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      opc_q      <= opc_d;
      len_q      <= len_d;
      pay_cnt_q  <= pay_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      have_acc_q <= have_acc_d;
      run_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    opc_d       = opc_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    have_acc_d  = have_acc_q;
    rx_ready_o  = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    alu_valid_o = 1'b0;

    case (state_q)
      ST_HDR: begin
        // run_q keeps the receiver stalled while reset is asserted.
        rx_ready_o = run_q;
        if (rx_valid_i && run_q) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd0: opc_d = rx_data_i;
            2'd2: len_d[7:0] = rx_data_i;
            2'd3: begin
              len_d[15:8] = rx_data_i;
              pay_cnt_d   = '0;
              byte_cnt_d  = '0;
              acc_d       = '0;
              opnd_d      = '0;
              have_acc_d  = 1'b0;
              if ({rx_data_i, len_q[7:0]} <= HDR_LEN) begin
                state_d = ST_HDR;
              end else begin
                case (opc_q)
                  OPC_ECHO:                  state_d = ST_ECHO;
                  OPC_ADD, OPC_MUL, OPC_DIV: state_d = ST_LOAD;
                  default:                   state_d = ST_DRAIN;
                endcase
              end
            end
            default: ;
          endcase
        end
      end

      ST_ECHO: begin
        tx_data_o  = rx_data_i;
        tx_valid_o = rx_valid_i;
        rx_ready_o = tx_ready_i;
        if (rx_valid_i && tx_ready_i) begin
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (pay_last) state_d = ST_HDR;
        end
      end

      ST_LOAD: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          opnd_d    = opnd_shift;
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (byte_cnt_q == BC_LAST) begin
            byte_cnt_d = '0;
            if (!have_acc_q) begin
              acc_d      = opnd_shift;
              have_acc_d = 1'b1;
              state_d    = pay_last ? ST_SEND : ST_LOAD;
            end else begin
              state_d = ST_REQ;
            end
          end else if (pay_last) begin
            // Trailing partial operand is discarded.
            byte_cnt_d = '0;
            state_d    = ST_SEND;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_ONE;
          end
        end
      end

      ST_REQ: begin
        alu_valid_o = 1'b1;
        if (alu_ready_i) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (alu_result_valid_i) begin
          acc_d   = alu_result_i;
          state_d = pay_done ? ST_SEND : ST_LOAD;
        end
      end

      ST_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = acc_q[BW-1:0];
        if (tx_ready_i) begin
          acc_d = acc_q >> BW;
          if (byte_cnt_q == BC_LAST) begin
            byte_cnt_d = '0;
            state_d    = ST_HDR;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_ONE;
          end
        end
      end

      ST_DRAIN: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (pay_last) state_d = ST_HDR;
        end
      end

      default: state_d = ST_HDR;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_pkt_ctrl.sv
// tb_alu_pkt_ctrl -- scoreboard bench for alu_pkt_ctrl with a behavioural ALU.
// Rev 1.0
`default_nettype none

module tb_alu_pkt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready;
  logic [31:0] alu_result;
  logic        alu_result_valid;

  always #5 clk = ~clk;

  alu_pkt_ctrl #(.opw_p(32), .datawidth_p(8)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .rx_data_i          (rx_data),
    .rx_valid_i         (rx_valid),
    .rx_ready_o         (rx_ready_o),
    .tx_data_o          (tx_data_o),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready),
    .alu_op_o           (alu_op_o),
    .alu_a_o            (alu_a_o),
    .alu_b_o            (alu_b_o),
    .alu_valid_o        (alu_valid_o),
    .alu_ready_i        (alu_ready),
    .alu_result_i       (alu_result),
    .alu_result_valid_i (alu_result_valid)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [7:0]  opc;
    logic [1:0]  nops;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  npart;
    logic [31:0] res;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_tx_q[$];
  alu_req_t    exp_alu_q[$];
  logic [7:0]  pkt[$];
  bit          rand_bp = 1'b0;
  bit          hold_tx = 1'b0;
  vec_t        vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  function automatic logic [1:0] opc_code(input logic [7:0] opc);
    case (opc)
      8'h88:   return 2'd1;
      8'hD1:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // TX side: drives ready, pops the scoreboard on every transfer.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = hold_tx ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      #4;
      if (tx_valid_o && tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %h expected no byte", tx_data_o);
        end else begin
          chk("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_tx_q.pop_front()});
        end
      end
    end
  end

  // Behavioural ALU: random accept, result strobe two cycles after the request.
  initial begin
    int          pend;
    logic [31:0] pend_res;
    bit          stalled;
    logic [31:0] held_a, held_b;
    alu_req_t    e;
    pend = 0; pend_res = '0; stalled = 1'b0; held_a = '0; held_b = '0;
    alu_ready = 1'b0; alu_result_valid = 1'b0; alu_result = '0;
    forever begin
      @(negedge clk);
      alu_result_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          alu_result_valid = 1'b1;
          alu_result       = pend_res;
        end
      end
      alu_ready = ($urandom_range(0, 2) == 0);
      #4;
      if (stalled) begin
        chk("alu_valid_hold", {31'd0, alu_valid_o}, 32'd1);
        chk("alu_a_hold", alu_a_o, held_a);
        chk("alu_b_hold", alu_b_o, held_b);
      end
      stalled = 1'b0;
      if (alu_valid_o) begin
        if (alu_ready) begin
          if (exp_alu_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL alu_unexpected: got a=%h b=%h expected no request", alu_a_o, alu_b_o);
          end else begin
            e = exp_alu_q.pop_front();
            chk("alu_op", {30'd0, alu_op_o}, {30'd0, e.op});
            chk("alu_a", alu_a_o, e.a);
            chk("alu_b", alu_b_o, e.b);
            pend_res = alu_model(e.op, e.a, e.b);
            pend     = 2;
          end
        end else begin
          stalled = 1'b1;
          held_a  = alu_a_o;
          held_b  = alu_b_o;
        end
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      #4;
      if (rx_ready_o) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL rx_timeout: got no rx_ready_o expected handshake within 3000 cycles");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rx_idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) rx_byte(pkt[i]);
    rx_idle();
    pkt.delete();
  endtask

  task automatic hdr(input logic [7:0] opc, input int len);
    logic [15:0] l;
    l = 16'(len);
    pkt.push_back(opc);
    pkt.push_back(8'h00);
    pkt.push_back(l[7:0]);
    pkt.push_back(l[15:8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) pkt.push_back(w[8*k +: 8]);
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_tx_q.push_back(w[8*k +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || exp_alu_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk({name, "_tx_left"}, exp_tx_q.size(), 32'd0);
    chk({name, "_alu_left"}, exp_alu_q.size(), 32'd0);
    exp_tx_q.delete();
    exp_alu_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] acc, opv;
    alu_req_t    r;
    acc = '0;
    hdr(v.opc, 4 + 4 * int'(v.nops) + int'(v.npart));
    for (int k = 0; k < int'(v.nops); k++) begin
      opv = (k == 0) ? v.op0 : ((k == 1) ? v.op1 : v.op2);
      push_word(opv);
      if (k == 0) begin
        acc = opv;
      end else begin
        r.op = opc_code(v.opc);
        r.a  = acc;
        r.b  = opv;
        exp_alu_q.push_back(r);
        acc = alu_model(r.op, acc, opv);
      end
    end
    for (int k = 0; k < int'(v.npart); k++) pkt.push_back(8'hEE);
    exp_word(v.res);
    send_pkt();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rx_ready"}, {31'd0, rx_ready_o}, 32'd0);
    chk({name, "_tx_valid"}, {31'd0, tx_valid_o}, 32'd0);
    chk({name, "_alu_valid"}, {31'd0, alu_valid_o}, 32'd0);
    chk({name, "_tx_data"}, {24'd0, tx_data_o}, 32'd0);
    chk({name, "_alu_op"}, {30'd0, alu_op_o}, 32'd0);
    chk({name, "_alu_a"}, alu_a_o, 32'd0);
    chk({name, "_alu_b"}, alu_b_o, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{8'hAD, 2'd2, 32'd1,          32'd2,      32'd0, 2'd0, 32'd3};
    vecs[1] = '{8'h88, 2'd1, 32'd5,          32'd0,      32'd0, 2'd0, 32'd5};
    vecs[2] = '{8'h88, 2'd3, 32'd3,          32'd4,      32'd5, 2'd0, 32'd60};
    vecs[3] = '{8'hAD, 2'd2, 32'h10,         32'h20,     32'd0, 2'd2, 32'h30};
    vecs[4] = '{8'hD1, 2'd2, 32'd100,        32'd7,      32'd0, 2'd0, 32'd14};
    vecs[5] = '{8'hD1, 2'd2, 32'd10,         32'd0,      32'd0, 2'd0, 32'hFFFF_FFFF};
    vecs[6] = '{8'hAD, 2'd0, 32'd0,          32'd0,      32'd0, 2'd3, 32'd0};
    vecs[7] = '{8'hAD, 2'd2, 32'hFFFF_FFFF,  32'd2,      32'd0, 2'd1, 32'd1};
    vecs[8] = '{8'h88, 2'd2, 32'h0001_2345,  32'h100,    32'd0, 2'd0, 32'h0123_4500};

    repeat (3) @(negedge clk);
    #4;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Echo passthrough.
    hdr(8'hEC, 7);
    pkt.push_back(8'h41); pkt.push_back(8'h42); pkt.push_back(8'h43);
    exp_tx_q.push_back(8'h41); exp_tx_q.push_back(8'h42); exp_tx_q.push_back(8'h43);
    send_pkt();
    wait_drain("echo");

    for (int i = 0; i < 9; i++) begin
      rand_bp = (i % 2) == 1;
      run_vec(vecs[i]);
      wait_drain("vec");
    end
    rand_bp = 1'b0;

    // Unknown opcode drains silently, next packet still parsed.
    hdr(8'h7F, 6);
    pkt.push_back(8'hAA); pkt.push_back(8'hBB);
    send_pkt();
    hdr(8'hEC, 5);
    pkt.push_back(8'h5A);
    exp_tx_q.push_back(8'h5A);
    send_pkt();
    wait_drain("unknown");

    // Headers with length <= 4 produce nothing.
    hdr(8'hAD, 4);
    send_pkt();
    hdr(8'hAD, 0);
    send_pkt();
    hdr(8'hEC, 5);
    pkt.push_back(8'h66);
    exp_tx_q.push_back(8'h66);
    send_pkt();
    wait_drain("shortlen");

    // Drain with a length needing the MSB byte.
    hdr(8'h12, 16'h0105);
    for (int k = 0; k < 16'h0105 - 4; k++) pkt.push_back(8'(k));
    send_pkt();
    hdr(8'hEC, 5);
    pkt.push_back(8'h77);
    exp_tx_q.push_back(8'h77);
    send_pkt();
    wait_drain("drain");

    // Echo under random TX backpressure.
    rand_bp = 1'b1;
    hdr(8'hEC, 14);
    for (int k = 0; k < 10; k++) begin
      pkt.push_back(8'(8'hC0 + k));
      exp_tx_q.push_back(8'(8'hC0 + k));
    end
    send_pkt();
    wait_drain("echo_bp");
    rand_bp = 1'b0;

    // Stalled SEND holds valid and data.
    @(posedge clk);
    hold_tx = 1'b1;
    begin
      alu_req_t r;
      r.op = 2'd0; r.a = 32'h1122_3340; r.b = 32'h4;
      exp_alu_q.push_back(r);
    end
    hdr(8'hAD, 12);
    push_word(32'h1122_3340);
    push_word(32'h4);
    exp_word(32'h1122_3344);
    send_pkt();
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      #4;
      if (tx_valid_o) break;
      n++;
    end
    chk("bp_valid_seen", {31'd0, tx_valid_o}, 32'd1);
    chk("bp_first_byte", {24'd0, tx_data_o}, 32'h44);
    repeat (20) begin
      @(negedge clk);
      #4;
      chk("bp_valid_hold", {31'd0, tx_valid_o}, 32'd1);
      chk("bp_data_hold", {24'd0, tx_data_o}, 32'h44);
    end
    @(posedge clk);
    hold_tx = 1'b0;
    wait_drain("backpressure");

    // Reset in the middle of an ADD packet.
    rx_byte(8'hAD); rx_byte(8'h00); rx_byte(8'h0C); rx_byte(8'h00); rx_byte(8'h01);
    rx_idle();
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hdr(8'hEC, 5);
    pkt.push_back(8'h5A);
    exp_tx_q.push_back(8'h5A);
    send_pkt();
    wait_drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
